vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing core. Generates the raster counters, sync pulses and data-enable for any mode set through parameters.
- Issues pixel requests to the graphics generator LAT cycles ahead of display. Registers the returned colour so that RGB, hsync, vsync and de leave the block cycle-aligned.
- Sits between the pixel-clock domain and the board VGA DAC/connector. The graphics generator hangs off the req_*/pix_* interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- LAT, 2, request-to-display latency in clocks (legal range 1..8)
- CW, 4, bits per colour channel
- XW, 10, width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- vgaclk, in, 1, pixel clock
- rst, in, 1, asynchronous active-low reset
- en, in, 1, run enable; low acts as synchronous soft clear
- hc, out, XW, horizontal counter (request stage)
- vc, out, XW, vertical counter (request stage)
- req_valid, out, 1, high when (hc,vc) is inside the active area
- req_x, out, XW, requested pixel column (equals hc)
- req_y, out, XW, requested pixel row (equals vc)
- pix_r / pix_g / pix_b, in, CW each, colour from the generator for the request made LAT-1 cycles earlier
- red / green / blue, out, CW each, registered colour to the DAC
- hsync, out, 1, registered horizontal sync
- vsync, out, 1, registered vertical sync
- de, out, 1, registered display enable
- frame_start, out, 1, one-cycle pulse with the first displayed pixel of a frame
- line_start, out, 1, one-cycle pulse with the first displayed pixel of each line

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. All comparisons are done at XW bits.
- Counters:
  - hc increments every clock while en=1.
  - At hc=H_TOTAL-1: hc goes to 0 and vc increments.
  - At (H_TOTAL-1, V_TOTAL-1): both go to 0 on the next clock. No extra blanking clocks are inserted.
- Request stage (combinational from counters):
  - req_valid = (hc<H_ACTIVE) && (vc<V_ACTIVE). Strict less-than, so column H_ACTIVE-1 and row V_ACTIVE-1 are visible.
  - raw hsync is active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - raw vsync is active for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (whole lines).
- Pipeline: raw hsync, vsync, req_valid, line-start (hc==0 && req_valid) and frame-start (hc==0 && vc==0) pass through a LAT-deep register chain.
- Output stage:
  - On the clock edge ending cycle t+LAT-1, red/green/blue <= de_next ? pix_* : 0.
  - de_next is req_valid from cycle t.
  - At the same edge, hsync/vsync/de/frame_start/line_start take their stage-LAT values.
- Alignment: a request at cycle t appears on outputs during cycle t+LAT. The generator must hold pix_* valid during cycle t+LAT-1.
- Sync polarity: output level = active ? HS_POL : ~HS_POL (VS_POL for vsync).
- Reset (rst=0, asynchronous):
  - hc=vc=0.
  - All pipeline stages cleared to inactive.
  - red=green=blue=0, de=0, frame_start=line_start=0.
  - hsync=~HS_POL, vsync=~VS_POL.
- Reset release: the counters start at (0,0) on the first clock. The first frame_start occurs LAT cycles after release.
- en=0 (synchronous):
  - Counters forced to 0.
  - Pipeline loads the inactive state; req_valid is forced 0.
  - Outputs go inactive on the next edge.
  - On en rising, behaviour is identical to reset release.
- Mid-frame reset or en drop: no partial pulse completes. Sync drops to inactive immediately (async reset) or on the next edge (en).
- pix_* are ignored, and outputs black, whenever de_next=0, including the porches and sync.

Test Plan:
- Default params, LAT=2, release reset → frame_start at cycle 2. Counters hit (799,524) then (0,0). 800 clocks/line, 420000 clocks/frame.
- Default params, count hsync low clocks per line → exactly 96 clocks, starting at output cycle with delayed hc=656. vsync low exactly 2×800 clocks starting at line 490.
- Drive pix_r = req_x[3:0] delayed by LAT-1 → red at output column x equals x[3:0] for x=0..639. Red=0 at delayed hc=640..799 and at lines 480..524.
- HS_POL=1, VS_POL=1 → sync idle 0, active 1. Repeat with LAT=1 and LAT=5; alignment holds with rgb/de/sync shifted by LAT.
- Assert rst=0 at hc=700, vc=491 (mid-vsync) → hsync/vsync immediately inactive, rgb=0. Restart from (0,0).
- Drop en for 3 cycles at hc=100, vc=10 → de=0 on next edge. On re-enable, frame_start fires LAT cycles later; line_start fires once per line thereafter.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing core: raster counters, sync and display-enable generation,
// plus a LAT-deep pipeline that lines the generator's colour up with the sync outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LAT      = 2,
  parameter int CW       = 4,
  parameter int XW       = 10
) (
  input  logic          vgaclk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] hc,
  output logic [XW-1:0] vc,
  output logic          req_valid,
  output logic [XW-1:0] req_x,
  output logic [XW-1:0] req_y,
  input  logic [CW-1:0] pix_r,
  input  logic [CW-1:0] pix_g,
  input  logic [CW-1:0] pix_b,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] V_LAST = XW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] V_ACT  = XW'(V_ACTIVE);
  localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] V_SS   = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0] V_SE   = XW'(V_ACTIVE + V_FP + V_SYNC);

  // Bit positions inside one pipeline stage; every bit is active-high internally.
  localparam int S_HS = 0;
  localparam int S_VS = 1;
  localparam int S_DE = 2;
  localparam int S_LS = 3;
  localparam int S_FS = 4;

  logic [XW-1:0] r_hc;
  logic [XW-1:0] r_vc;
  logic [4:0]    r_pipe [LAT];
  logic [CW-1:0] r_red;
  logic [CW-1:0] r_green;
  logic [CW-1:0] r_blue;

  logic          w_req_valid;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [4:0]    w_stage0;
  logic [4:0]    w_out;
  logic          w_de_next;

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (!en) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == V_LAST) ? '0 : r_vc + XW'(1);
    end else begin
      r_hc <= r_hc + XW'(1);
    end
  end

  assign w_req_valid = en && (r_hc < H_ACT) && (r_vc < V_ACT);
  assign w_hs_act    = (r_hc >= H_SS) && (r_hc < H_SE);
  assign w_vs_act    = (r_vc >= V_SS) && (r_vc < V_SE);
  assign w_stage0    = {(r_hc == '0) && (r_vc == '0),
                        (r_hc == '0) && w_req_valid,
                        w_req_valid, w_vs_act, w_hs_act};

  // The last stage doubles as the registered sync/de/pulse outputs.
  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (!en) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign w_de_next = w_req_valid;
    end else begin : g_latn
      assign w_de_next = r_pipe[LAT-2][S_DE];
    end
  endgenerate

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (!en || !w_de_next) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= pix_r;
      r_green <= pix_g;
      r_blue  <= pix_b;
    end
  end

  assign w_out       = r_pipe[LAT-1];
  assign hc          = r_hc;
  assign vc          = r_vc;
  assign req_valid   = w_req_valid;
  assign req_x       = r_hc;
  assign req_y       = r_vc;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign hsync       = w_out[S_HS] ? HS_POL : ~HS_POL;
  assign vsync       = w_out[S_VS] ? VS_POL : ~VS_POL;
  assign de          = w_out[S_DE];
  assign line_start  = w_out[S_LS];
  assign frame_start = w_out[S_FS];

endmodule
